// File: rtl/seg7_pkg.sv
// Shared 7-segment code definitions, common to the display encoder and the frame decoder.
// Segment bus is active-high: bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
package seg7_pkg;

    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    localparam logic [6:0] SEG_0     = 7'd62;
    localparam logic [6:0] SEG_0_ALT = 7'd126;
    localparam logic [6:0] SEG_1     = 7'd48;
    localparam logic [6:0] SEG_2     = 7'd109;
    localparam logic [6:0] SEG_3     = 7'd121;
    localparam logic [6:0] SEG_4     = 7'd51;
    localparam logic [6:0] SEG_5     = 7'd91;
    localparam logic [6:0] SEG_6     = 7'd95;
    localparam logic [6:0] SEG_7     = 7'd112;
    localparam logic [6:0] SEG_8     = 7'd127;
    localparam logic [6:0] SEG_9     = 7'd123;
    localparam logic [6:0] SEG_A     = 7'd119;
    localparam logic [6:0] SEG_B     = 7'd31;
    localparam logic [6:0] SEG_C     = 7'd78;
    localparam logic [6:0] SEG_D     = 7'd61;
    localparam logic [6:0] SEG_E     = 7'd79;
    localparam logic [6:0] SEG_F     = 7'd71;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_HELD = 1'b1
    } cap_state_e;

endpackage

// File: rtl/seg7_to_nibble.sv
// Inverse of the display encoder: 7-bit segment code to {err, nibble}.
// Unknown patterns (including blank) decode to 0 with err set.
module seg7_to_nibble
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [4:0] dec_o
);

    always_comb begin
        dec_o = {1'b1, 4'h0};
        case (seg_i)
            SEG_0, SEG_0_ALT: dec_o = {1'b0, 4'h0};
            SEG_1:            dec_o = {1'b0, 4'h1};
            SEG_2:            dec_o = {1'b0, 4'h2};
            SEG_3:            dec_o = {1'b0, 4'h3};
            SEG_4:            dec_o = {1'b0, 4'h4};
            SEG_5:            dec_o = {1'b0, 4'h5};
            SEG_6:            dec_o = {1'b0, 4'h6};
            SEG_7:            dec_o = {1'b0, 4'h7};
            SEG_8:            dec_o = {1'b0, 4'h8};
            SEG_9:            dec_o = {1'b0, 4'h9};
            SEG_A:            dec_o = {1'b0, 4'hA};
            SEG_B:            dec_o = {1'b0, 4'hB};
            SEG_C:            dec_o = {1'b0, 4'hC};
            SEG_D:            dec_o = {1'b0, 4'hD};
            SEG_E:            dec_o = {1'b0, 4'hE};
            SEG_F:            dec_o = {1'b0, 4'hF};
            default:          dec_o = {1'b1, 4'h0};
        endcase
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Recovers a frame of digit values from a multiplexed 7-segment bus and offers it on valid/ready.
//   state   | meaning
//   ST_WAIT | waiting for the synchronised (seg, sel) pair to settle; captures once stable
//   ST_HELD | pair already captured this dwell; waits for the next sample change
module seg7_frame_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_sel,
    output logic [4*NUM_DIGITS-1:0]   out_digits,
    output logic [NUM_DIGITS-1:0]     out_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overrun
);

    localparam logic [7:0]            CAP_CNT = 8'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

    logic [6:0]              seg_s1_q, seg_s2_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   sel_s1_q, sel_s2_q, sel_prev_q;
    logic [7:0]              cnt_q, cnt_d;
    cap_state_e              state_q, state_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d, mask_set;
    logic [4*NUM_DIGITS-1:0] slot_dig_q, slot_dig_d;
    logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
    logic [4*NUM_DIGITS-1:0] out_dig_q, out_dig_d;
    logic [NUM_DIGITS-1:0]   out_err_q, out_err_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;

    logic                    changed;
    logic                    sel_onehot;
    logic                    capture;
    logic                    complete;
    logic [4:0]              dec;

    seg7_to_nibble u_dec (
        .seg_i (seg_s2_q),
        .dec_o (dec)
    );

    assign changed    = (seg_s2_q != seg_prev_q) || (sel_s2_q != sel_prev_q);
    assign sel_onehot = (sel_s2_q != '0) && ((sel_s2_q & (sel_s2_q - SEL_ONE)) == '0);

    // Compare against the next count so capture lands on the edge the count reaches the threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (changed) begin
            cnt_d = 8'd0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if ((cnt_d == CAP_CNT) && sel_onehot) begin
                    capture = 1'b1;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (changed) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        slot_dig_d = slot_dig_q;
        slot_err_d = slot_err_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && sel_s2_q[i]) begin
                slot_dig_d[4*i +: 4] = dec[3:0];
                slot_err_d[i]        = dec[4];
            end
        end
        mask_set = mask_q | (capture ? sel_s2_q : '0);
        complete = capture && (&mask_set);
        mask_d   = complete ? '0 : mask_set;
    end

    always_comb begin
        out_dig_d = out_dig_q;
        out_err_d = out_err_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        if (complete) begin
            if (!valid_q || out_ready) begin
                out_dig_d = slot_dig_d;
                out_err_d = slot_err_d;
                valid_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q   <= '0;
            seg_s2_q   <= '0;
            seg_prev_q <= '0;
            sel_s1_q   <= '0;
            sel_s2_q   <= '0;
            sel_prev_q <= '0;
            cnt_q      <= '0;
            state_q    <= ST_WAIT;
            mask_q     <= '0;
            slot_dig_q <= '0;
            slot_err_q <= '0;
            out_dig_q  <= '0;
            out_err_q  <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            seg_s1_q   <= seg_in;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            sel_s1_q   <= dig_sel;
            sel_s2_q   <= sel_s1_q;
            sel_prev_q <= sel_s2_q;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            mask_q     <= mask_d;
            slot_dig_q <= slot_dig_d;
            slot_err_q <= slot_err_d;
            out_dig_q  <= out_dig_d;
            out_err_q  <= out_err_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign out_digits = out_dig_q;
    assign out_err    = out_err_q;
    assign out_valid  = valid_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder: decode table frames plus glitch, select,
// back-pressure, simultaneous-handshake and async-reset sequences.
module tb_seg7_frame_decoder;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] out_digits;
    logic [3:0]  out_err;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;

    int total;
    int bad;
    int nacc;
    logic [15:0] last_dig;
    logic [3:0]  last_err;

    seg7_frame_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .dig_sel    (dig_sel),
        .out_digits (out_digits),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted frame; sampled mid-cycle, the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            nacc     = nacc + 1;
            last_dig = out_digits;
            last_err = out_err;
        end
    end

    typedef struct packed {
        logic [6:0]  c0;
        logic [6:0]  c1;
        logic [6:0]  c2;
        logic [6:0]  c3;
        logic [15:0] dig;
        logic [3:0]  err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
        seg_in  = s;
        dig_sel = d;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [6:0] c0, input logic [6:0] c1,
                              input logic [6:0] c2, input logic [6:0] c3);
        drive(c0, 4'b0001, 8);
        drive(c1, 4'b0010, 8);
        drive(c2, 4'b0100, 8);
        drive(c3, 4'b1000, 8);
        drive(7'd0, 4'b0000, 6);
    endtask

    int n0;

    initial begin
        total     = 0;
        bad       = 0;
        nacc      = 0;
        last_dig  = '0;
        last_err  = '0;
        rst_n     = 1'b0;
        seg_in    = '0;
        dig_sel   = '0;
        out_ready = 1'b1;

        vecs[0] = '{c0: 7'd48,  c1: 7'd109, c2: 7'd121, c3: 7'd51,  dig: 16'h4321, err: 4'b0000};
        vecs[1] = '{c0: 7'd126, c1: 7'd62,  c2: 7'd127, c3: 7'd123, dig: 16'h9800, err: 4'b0000};
        vecs[2] = '{c0: 7'd119, c1: 7'd31,  c2: 7'd78,  c3: 7'd61,  dig: 16'hDCBA, err: 4'b0000};
        vecs[3] = '{c0: 7'd79,  c1: 7'd71,  c2: 7'd112, c3: 7'd95,  dig: 16'h67FE, err: 4'b0000};
        vecs[4] = '{c0: 7'd0,   c1: 7'd48,  c2: 7'd0,   c3: 7'd5,   dig: 16'h0010, err: 4'b1101};
        vecs[5] = '{c0: 7'd91,  c1: 7'd48,  c2: 7'd0,   c3: 7'd48,  dig: 16'h1015, err: 4'b0100};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits", 32'(out_digits), 32'h0);
        chk("rst_err", 32'(out_err), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        drive(7'd0, 4'b0000, 2);

        for (int v = 0; v < 6; v++) begin
            n0 = nacc;
            send_frame(vecs[v].c0, vecs[v].c1, vecs[v].c2, vecs[v].c3);
            chk($sformatf("vec%0d_frames", v), 32'(nacc - n0), 32'd1);
            chk($sformatf("vec%0d_digits", v), 32'(last_dig), 32'(vecs[v].dig));
            chk($sformatf("vec%0d_err", v), 32'(last_err), 32'(vecs[v].err));
        end

        // Short glitches inside the slot0 dwell; slot3 held for exactly STABLE_CYCLES+1
        n0 = nacc;
        drive(7'd48,  4'b0001, 6);
        drive(7'd127, 4'b0001, 3);
        drive(7'd48,  4'b0001, 6);
        drive(7'd127, 4'b0001, 2);
        drive(7'd48,  4'b0001, 8);
        drive(7'd109, 4'b0010, 8);
        drive(7'd121, 4'b0100, 8);
        drive(7'd51,  4'b1000, 5);
        drive(7'd0,   4'b0000, 6);
        chk("glitch_frames", 32'(nacc - n0), 32'd1);
        chk("glitch_digits", 32'(last_dig), 32'h4321);
        chk("glitch_err", 32'(last_err), 32'h0);

        // Non-one-hot selects never capture
        n0 = nacc;
        drive(7'd48,  4'b0001, 8);
        drive(7'd109, 4'b0010, 8);
        drive(7'd121, 4'b0100, 8);
        drive(7'd51,  4'b0011, 10);
        drive(7'd51,  4'b0000, 10);
        chk("badsel_noframe", 32'(nacc - n0), 32'd0);
        drive(7'd51,  4'b1000, 8);
        drive(7'd0,   4'b0000, 6);
        chk("badsel_frames", 32'(nacc - n0), 32'd1);
        chk("badsel_digits", 32'(last_dig), 32'h4321);
        chk("badsel_err", 32'(last_err), 32'h0);

        // Completion coincides with the handshake of the held frame
        out_ready = 1'b0;
        n0 = nacc;
        send_frame(7'd48, 7'd109, 7'd121, 7'd51);
        chk("simul_heldA", 32'(out_valid), 32'd1);
        drive(7'd91,  4'b0001, 8);
        drive(7'd95,  4'b0010, 8);
        drive(7'd112, 4'b0100, 8);
        drive(7'd127, 4'b1000, 5);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("simul_valid", 32'(out_valid), 32'd1);
        chk("simul_digits", 32'(out_digits), 32'h8765);
        chk("simul_overrun", 32'(overrun), 32'd0);
        chk("simul_acceptA", 32'(nacc - n0), 32'd1);
        chk("simul_lastA", 32'(last_dig), 32'h4321);
        drive(7'd0, 4'b0000, 4);
        out_ready = 1'b1;
        drive(7'd0, 4'b0000, 2);
        chk("simul_acceptB", 32'(nacc - n0), 32'd2);
        chk("simul_lastB", 32'(last_dig), 32'h8765);
        chk("simul_drained", 32'(out_valid), 32'd0);

        // Back-pressure across two frames
        out_ready = 1'b0;
        n0 = nacc;
        send_frame(7'd48, 7'd109, 7'd121, 7'd51);
        send_frame(7'd91, 7'd95, 7'd112, 7'd127);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_digits", 32'(out_digits), 32'h4321);
        chk("bp_overrun", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_accept", 32'(nacc - n0), 32'd1);
        chk("bp_last", 32'(last_dig), 32'h4321);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Async reset with a held frame and a partial frame
        out_ready = 1'b0;
        send_frame(7'd119, 7'd31, 7'd78, 7'd61);
        chk("ar_held", 32'(out_valid), 32'd1);
        drive(7'd48,  4'b0001, 8);
        drive(7'd109, 4'b0010, 4);
        rst_n = 1'b0;
        #2;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_digits", 32'(out_digits), 32'h0);
        chk("ar_err", 32'(out_err), 32'h0);
        chk("ar_overrun", 32'(overrun), 32'd0);
        drive(7'd0, 4'b0000, 2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        n0 = nacc;
        drive(7'd112, 4'b0100, 8);
        drive(7'd127, 4'b1000, 8);
        drive(7'd0,   4'b0000, 6);
        chk("ar_partial", 32'(nacc - n0), 32'd0);
        drive(7'd91,  4'b0001, 8);
        drive(7'd95,  4'b0010, 8);
        drive(7'd0,   4'b0000, 6);
        chk("ar_frames", 32'(nacc - n0), 32'd1);
        chk("ar_new_digits", 32'(last_dig), 32'h8765);
        chk("ar_new_err", 32'(last_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
